mem_access_unit: RTL and testbench
==================================

Name: mem_access_unit

Overview:
- Sits between the MEM-stage pipeline signals and the word-wide data memory.
- Converts byte addresses to word indices and performs byte/halfword/word loads with sign or zero extension.
- Implements sub-word stores as a registered two-cycle read-modify-write, because the data memory only supports full-word writes.
- Drives a stall to the pipeline while the merge completes.

Parameters:
- ADDR_W, 8, width of the data-memory word index (256 words).
- XLEN, 32, data and address width.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- MemReadM  in  1  load request
- MemWriteM  in  1  store request
- funct3M  in  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
- ALUResultM  in  XLEN  byte address
- WriteDataM  in  XLEN  store data, right-aligned
- DM_ReadData  in  XLEN  asynchronous read word from data memory
- DM_Addr  out  ADDR_W  word index to data memory
- DM_WriteData  out  XLEN  word to data memory
- DM_WE  out  1  data-memory write enable
- ReadDataM  out  XLEN  aligned, extended load result
- StallM  out  1  freezes the pipeline for one cycle during a sub-word store
- MisalignedM  out  1  misaligned access flag (see Optional Feature)

Behaviour:
- Reset is asynchronous and active-high. On reset:
  - state=IDLE; all capture registers cleared.
  - DM_WE=0, StallM=0, ReadDataM=0, MisalignedM=0, DM_Addr=0, DM_WriteData=0.
  - DM_WE is gated by !rst, so a reset asserted mid-MERGE produces no write.
- Word index: DM_Addr = ALUResultM[ADDR_W+1:2] in IDLE; the latched index in MERGE. Upper address bits are ignored (wrap modulo 2^ADDR_W words). Byte offset off = ALUResultM[1:0].
- Loads, IDLE only, combinational, zero added latency:
  - B/BU select byte off, then sign- or zero-extend.
  - H/HU select halfword off[1], then sign- or zero-extend.
  - W returns the full word.
  - ReadDataM=0 when there is no load, funct3 is illegal, or state is MERGE.
- Full-word store, IDLE: DM_WE=1 and DM_WriteData=WriteDataM in the same cycle. No stall.
- Sub-word store (SB/SH), IDLE:
  - DM_WE=0, StallM=1.
  - At the clock edge, latch DM_ReadData into old_q, plus index, off, funct3 and WriteDataM[15:0]; go to MERGE.
- MERGE:
  - DM_Addr=latched index; DM_WriteData=old_q with the target byte or halfword replaced; DM_WE=1; StallM=0.
  - Next state is IDLE unconditionally. Inputs are ignored; the pipeline holds them stable and they are not re-accepted.
- State machine transitions: IDLE→MERGE on a legal SB/SH. All other requests stay in IDLE. MERGE→IDLE always.
- MemReadM and MemWriteM both high: treat as a store; ReadDataM=0.
- Illegal funct3 (011, 110, 111): no access, DM_WE=0, ReadDataM=0, StallM=0.
- Back-to-back stores: a store following an SB/SH starts in the IDLE cycle after MERGE. A following load reads the merged word, because it was written at the MERGE edge.

Optional Feature:
- Macro MEM_MISALIGN_TRAP_EN.
- Defined:
  - Halfword with off[0]=1, or word with off!=0, sets MisalignedM=1 combinationally.
  - The store is suppressed (DM_WE=0, no MERGE entry) and ReadDataM=0.
- Undefined:
  - MisalignedM is tied to 0.
  - Low offset bits are force-aligned: word ignores off; halfword uses off[1].

Decomposition:
- Shared package mem_pkg holds:
  - funct3 localparams F3_B, F3_H, F3_W, F3_BU, F3_HU
  - state encoding S_IDLE/S_MERGE
  - ADDR_W default
- One natural sub-module, load_extract: pure-combinational byte/halfword select and extend (word, off, funct3 → result).
- The store merge logic stays inline.

Test Plan:
- Memory word 0x8844_22F1 at index 3; LB addr 0x0C → 0xFFFF_FFF1. LBU → 0x0000_00F1. LH addr 0x0E → 0xFFFF_8844. LHU → 0x0000_8844.
- SW 0xDEADBEEF to addr 0x10: DM_WE=1 same cycle, index 4, StallM never asserted.
- Word 0x1122_3344 at index 5; SB 0xAB to addr 0x16: StallM=1 for one cycle, then DM_WE=1 with 0x11AB_3344. Subsequent LW addr 0x14 reads 0x11AB_3344.
- SH 0xBEEF to addr 0x16 over 0x1122_3344 → written 0xBEEF_3344. Immediately followed by SB 0x00 to addr 0x14 → final word 0xBEEF_3300.
- Assert rst during MERGE of an SB: DM_WE stays 0, StallM=0, memory word unchanged, FSM back in IDLE.
- With MEM_MISALIGN_TRAP_EN: SW to addr 0x11 → MisalignedM=1, DM_WE=0. Without the macro: the same access writes index 4 and MisalignedM=0.

Source files
------------

// File: rtl/mem_access_unit_pkg.sv
// -----------------------------------------------------------------------------
// mem_pkg
// Shared definitions for the MEM-stage memory access unit.
//   ADDR_W_DEFAULT : default width of the data-memory word index (256 words)
//   XLEN_DEFAULT   : default data / address width
//   F3_*           : funct3 access size/sign encodings
//   state_t        : merge FSM state encoding
//   f3_legal()     : true for the five defined access encodings
// -----------------------------------------------------------------------------
package mem_pkg;

   localparam int ADDR_W_DEFAULT = 8;
   localparam int XLEN_DEFAULT   = 32;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic {
      S_IDLE  = 1'b0,
      S_MERGE = 1'b1
   } state_t;

   function automatic logic f3_legal(input logic [2:0] f3);
      return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
             (f3 == F3_BU) || (f3 == F3_HU);
   endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// -----------------------------------------------------------------------------
// mem_access_unit_if
// Bundles the MEM-stage request signals and the data-memory port.
//   master : pipeline + data memory side (drives requests and DM_ReadData)
//   slave  : the access unit (drives memory controls, load result, stall)
// Signals:
//   MemReadM, MemWriteM, funct3M, ALUResultM, WriteDataM  pipeline request
//   DM_ReadData                                           async memory read
//   DM_Addr, DM_WriteData, DM_WE                          memory write port
//   ReadDataM, StallM, MisalignedM                        back to pipeline
// -----------------------------------------------------------------------------
interface mem_access_unit_if #(
   parameter int ADDR_W = 8,
   parameter int XLEN   = 32
);
   logic              MemReadM;
   logic              MemWriteM;
   logic [2:0]        funct3M;
   logic [XLEN-1:0]   ALUResultM;
   logic [XLEN-1:0]   WriteDataM;
   logic [XLEN-1:0]   DM_ReadData;
   logic [ADDR_W-1:0] DM_Addr;
   logic [XLEN-1:0]   DM_WriteData;
   logic              DM_WE;
   logic [XLEN-1:0]   ReadDataM;
   logic              StallM;
   logic              MisalignedM;

   modport master (
      output MemReadM, MemWriteM, funct3M, ALUResultM, WriteDataM, DM_ReadData,
      input  DM_Addr, DM_WriteData, DM_WE, ReadDataM, StallM, MisalignedM
   );

   modport slave (
      input  MemReadM, MemWriteM, funct3M, ALUResultM, WriteDataM, DM_ReadData,
      output DM_Addr, DM_WriteData, DM_WE, ReadDataM, StallM, MisalignedM
   );
endinterface

// File: rtl/mem_access_unit_load_extract.sv
// -----------------------------------------------------------------------------
// load_extract
// Pure-combinational load alignment: picks the byte/halfword addressed by the
// byte offset out of a memory word and sign- or zero-extends it.
//   word   in  XLEN  word read from data memory
//   off    in  2     byte offset within the word
//   funct3 in  3     access size/sign (B, H, W, BU, HU)
//   result out XLEN  aligned, extended value; 0 for an illegal funct3
// Halfwords use off[1] only and words ignore off (force-aligned access).
// -----------------------------------------------------------------------------
module load_extract
   import mem_pkg::*;
#(
   parameter int XLEN = XLEN_DEFAULT
) (
   input  logic [XLEN-1:0] word,
   input  logic [1:0]      off,
   input  logic [2:0]      funct3,
   output logic [XLEN-1:0] result
);

   logic [7:0]  byte_v;
   logic [15:0] half_v;

   always_comb begin
      // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
      byte_v = word[{off, 3'b000} +: 8];
      half_v = off[1] ? word[31:16] : word[15:0];
      result = '0;
      case (funct3)
         F3_B:    result = {{(XLEN-8){byte_v[7]}}, byte_v};
         F3_BU:   result = {{(XLEN-8){1'b0}}, byte_v};
         F3_H:    result = {{(XLEN-16){half_v[15]}}, half_v};
         F3_HU:   result = {{(XLEN-16){1'b0}}, half_v};
         F3_W:    result = word;
         default: result = '0;
      endcase
   end

endmodule

// File: rtl/mem_access_unit.sv
// -----------------------------------------------------------------------------
// mem_access_unit
// Glue between the MEM-stage pipeline signals and a word-wide data memory.
// Loads are combinational with sign/zero extension. Full-word stores write in
// the request cycle. Byte/halfword stores are a two-cycle read-modify-write:
// the IDLE cycle stalls the pipeline and captures the old word, the MERGE
// cycle writes the old word with the target byte/halfword replaced.
// Ports:
//   clk  in   system clock
//   rst  in   asynchronous, active-high reset
//   bus  slave modport of mem_access_unit_if (requests, memory port, results)
// Configuration:
//   MEM_MISALIGN_TRAP_EN  defined: misaligned H/W access raises MisalignedM
//                         and is suppressed. Undefined: MisalignedM=0 and
//                         low offset bits are ignored (force-aligned).
// -----------------------------------------------------------------------------
module mem_access_unit
   import mem_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEFAULT,
   parameter int XLEN   = XLEN_DEFAULT
) (
   input  logic           clk,
   input  logic           rst,
   mem_access_unit_if.slave bus
);

   state_t state_q, state_d;

   // Captured sub-word store context
   logic [XLEN-1:0]   old_q;
   logic [ADDR_W-1:0] idx_q;
   logic [1:0]        off_q;
   logic [2:0]        f3_q;
   logic [15:0]       wdata_q;

   logic [ADDR_W-1:0] idx;
   logic [1:0]        off;
   logic [2:0]        f3;
   logic              legal;
   logic              ld_req;
   logic              st_req;
   logic              st_word;
   logic              st_sub;
   logic              misaligned;
   logic [XLEN-1:0]   load_val;
   logic [XLEN-1:0]   merged;

   // Address bits above the word index wrap modulo 2^ADDR_W words.
   logic unused_addr_hi;
   assign unused_addr_hi = ^bus.ALUResultM[XLEN-1:ADDR_W+2];

   assign idx    = bus.ALUResultM[ADDR_W+1:2];
   assign off    = bus.ALUResultM[1:0];
   assign f3     = bus.funct3M;
   assign legal  = f3_legal(f3);
   // A simultaneous read and write request is a store.
   assign ld_req = bus.MemReadM && !bus.MemWriteM && legal;
   assign st_req = bus.MemWriteM;

`ifdef MEM_MISALIGN_TRAP_EN
   assign misaligned =
      (((ld_req && (f3 == F3_H || f3 == F3_HU)) || (st_req && f3 == F3_H)) && off[0]) ||
      ((ld_req || st_req) && f3 == F3_W && off != 2'b00);
`else
   assign misaligned = 1'b0;
`endif

   // Stores exist only as SB/SH/SW; the unsigned encodings are no-access stores.
   assign st_word = st_req && (f3 == F3_W) && !misaligned;
   assign st_sub  = st_req && (f3 == F3_B || f3 == F3_H) && !misaligned;

   load_extract #(.XLEN(XLEN)) u_load_extract (
      .word   (bus.DM_ReadData),
      .off    (off),
      .funct3 (f3),
      .result (load_val)
   );

   // Old word with the captured byte/halfword patched in.
   always_comb begin
      merged = old_q;
      if (f3_q == F3_B)
         merged[{off_q, 3'b000} +: 8] = wdata_q[7:0];
      else
         merged[{off_q[1], 4'b0000} +: 16] = wdata_q;
   end

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         state_q <= S_IDLE;
      else
         // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
         state_q <= state_d;
   end

   // Next-state logic
   always_comb begin
      state_d = S_IDLE;
      case (state_q)
         S_IDLE:  state_d = st_sub ? S_MERGE : S_IDLE;
         S_MERGE: state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Capture registers are loaded on the IDLE->MERGE edge only.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         old_q   <= '0;
         idx_q   <= '0;
         off_q   <= '0;
         f3_q    <= '0;
         wdata_q <= '0;
      end else if (state_q == S_IDLE && st_sub) begin
         old_q   <= bus.DM_ReadData;
         idx_q   <= idx;
         off_q   <= off;
         f3_q    <= f3;
         wdata_q <= bus.WriteDataM[15:0];
      end
   end

   // Output logic
   always_comb begin
      bus.DM_Addr      = '0;
      bus.DM_WriteData = '0;
      bus.DM_WE        = 1'b0;
      bus.ReadDataM    = '0;
      bus.StallM       = 1'b0;
      bus.MisalignedM  = 1'b0;
      // NOTE: outputs are gated by rst so a reset landing mid-MERGE cannot issue a write.
      if (!rst) begin
         case (state_q)
            S_IDLE: begin
               bus.DM_Addr     = idx;
               bus.MisalignedM = misaligned;
               if (st_word) begin
                  bus.DM_WE        = 1'b1;
                  bus.DM_WriteData = bus.WriteDataM;
               end else if (st_sub) begin
                  bus.StallM = 1'b1;
               end else if (ld_req && !misaligned) begin
                  bus.ReadDataM = load_val;
               end
            end
            S_MERGE: begin
               bus.DM_Addr      = idx_q;
               bus.DM_WriteData = merged;
               bus.DM_WE        = 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_access_unit.sv
// -----------------------------------------------------------------------------
// tb_mem_access_unit
// Directed bench: drives MEM-stage requests through the interface, models a
// 256-word data memory with asynchronous read, and compares outputs against
// hand-computed values. Inputs change 1 time unit after posedge, outputs are
// sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_mem_access_unit;
   import mem_pkg::*;

   logic clk;
   logic rst;
   int   n_checks;
   int   n_fail;

   mem_access_unit_if #(.ADDR_W(8), .XLEN(32)) bus ();

   mem_access_unit #(.ADDR_W(8), .XLEN(32)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   logic [31:0] mem [256];

   assign bus.DM_ReadData = mem[bus.DM_Addr];

   always @(posedge clk)
      if (bus.DM_WE) mem[bus.DM_Addr] <= bus.DM_WriteData;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic rd, input logic wr, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wdata);
      bus.MemReadM   = rd;
      bus.MemWriteM  = wr;
      bus.funct3M    = f3;
      bus.ALUResultM = addr;
      bus.WriteDataM = wdata;
   endtask

   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic sample();
      @(negedge clk);
   endtask

   task automatic store_word(input logic [31:0] addr, input logic [31:0] data);
      drive(1'b0, 1'b1, F3_W, addr, data);
      cycle();
      drive(1'b0, 1'b0, F3_W, 32'h0, 32'h0);
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      rst      = 1'b1;
      // A full-word store held during reset must not reach memory.
      drive(1'b0, 1'b1, F3_W, 32'h10, 32'h0BAD_0BAD);
      mem[4] = 32'h0;

      sample();
      check("rst_DM_WE",        {31'b0, bus.DM_WE},       32'h0);
      check("rst_StallM",       {31'b0, bus.StallM},      32'h0);
      check("rst_MisalignedM",  {31'b0, bus.MisalignedM}, 32'h0);
      check("rst_ReadDataM",    bus.ReadDataM,            32'h0);
      check("rst_DM_Addr",      {24'b0, bus.DM_Addr},     32'h0);
      check("rst_DM_WriteData", bus.DM_WriteData,         32'h0);
      cycle();
      rst = 1'b0;
      drive(1'b0, 1'b0, F3_W, 32'h0, 32'h0);

      store_word(32'h0C, 32'h8844_22F1);
      store_word(32'h14, 32'h1122_3344);

      // Loads from index 3
      drive(1'b1, 1'b0, F3_B, 32'h0C, 32'h0);
      sample();
      check("lb_addr",  {24'b0, bus.DM_Addr}, 32'h3);
      check("lb",       bus.ReadDataM, 32'hFFFF_FFF1);
      check("lb_no_we", {31'b0, bus.DM_WE}, 32'h0);
      cycle();
      drive(1'b1, 1'b0, F3_BU, 32'h0C, 32'h0);
      sample();
      check("lbu", bus.ReadDataM, 32'h0000_00F1);
      cycle();
      drive(1'b1, 1'b0, F3_H, 32'h0E, 32'h0);
      sample();
      check("lh", bus.ReadDataM, 32'hFFFF_8844);
      cycle();
      drive(1'b1, 1'b0, F3_HU, 32'h0E, 32'h0);
      sample();
      check("lhu", bus.ReadDataM, 32'h0000_8844);
      cycle();
      drive(1'b1, 1'b0, F3_W, 32'h40C, 32'h0);
      sample();
      check("lw_wrap_addr", {24'b0, bus.DM_Addr}, 32'h3);
      check("lw_wrap",      bus.ReadDataM, 32'h8844_22F1);
      cycle();
      drive(1'b1, 1'b0, 3'b110, 32'h0C, 32'h0);
      sample();
      check("ld_illegal", bus.ReadDataM, 32'h0);
      cycle();

      // Full-word store
      drive(1'b0, 1'b1, F3_W, 32'h10, 32'hDEAD_BEEF);
      sample();
      check("sw_we",    {31'b0, bus.DM_WE},   32'h1);
      check("sw_addr",  {24'b0, bus.DM_Addr}, 32'h4);
      check("sw_data",  bus.DM_WriteData,     32'hDEAD_BEEF);
      check("sw_stall", {31'b0, bus.StallM},  32'h0);
      cycle();
      drive(1'b0, 1'b0, F3_W, 32'h0, 32'h0);
      check("sw_mem", mem[4], 32'hDEAD_BEEF);

      // SB over 0x11223344 at index 5
      drive(1'b0, 1'b1, F3_B, 32'h16, 32'hFFFF_FFAB);
      sample();
      check("sb_stall", {31'b0, bus.StallM}, 32'h1);
      check("sb_no_we", {31'b0, bus.DM_WE},  32'h0);
      cycle();
      sample();
      check("sb_merge_stall", {31'b0, bus.StallM},  32'h0);
      check("sb_merge_we",    {31'b0, bus.DM_WE},   32'h1);
      check("sb_merge_addr",  {24'b0, bus.DM_Addr}, 32'h5);
      check("sb_merge_data",  bus.DM_WriteData,     32'h11AB_3344);
      check("sb_merge_rd",    bus.ReadDataM,        32'h0);
      cycle();
      drive(1'b1, 1'b0, F3_W, 32'h14, 32'h0);
      sample();
      check("lw_after_sb", bus.ReadDataM, 32'h11AB_3344);
      cycle();

      // SH then back-to-back SB
      store_word(32'h14, 32'h1122_3344);
      drive(1'b0, 1'b1, F3_H, 32'h16, 32'h0000_BEEF);
      sample();
      check("sh_stall", {31'b0, bus.StallM}, 32'h1);
      cycle();
      sample();
      check("sh_merge_data", bus.DM_WriteData, 32'hBEEF_3344);
      cycle();
      drive(1'b0, 1'b1, F3_B, 32'h14, 32'h0000_0000);
      sample();
      check("sb2_stall", {31'b0, bus.StallM}, 32'h1);
      cycle();
      sample();
      check("sb2_merge_data", bus.DM_WriteData, 32'hBEEF_3300);
      cycle();
      drive(1'b1, 1'b0, F3_W, 32'h14, 32'h0);
      sample();
      check("lw_after_sh_sb", bus.ReadDataM, 32'hBEEF_3300);
      cycle();
      drive(1'b1, 1'b0, F3_B, 32'h17, 32'h0);
      sample();
      check("lb_top_byte", bus.ReadDataM, 32'hFFFF_FFBE);
      cycle();

      // Read+write together is a store
      drive(1'b1, 1'b1, F3_W, 32'h1C, 32'h0102_0304);
      sample();
      check("rw_we",   {31'b0, bus.DM_WE},   32'h1);
      check("rw_addr", {24'b0, bus.DM_Addr}, 32'h7);
      check("rw_rd",   bus.ReadDataM,        32'h0);
      cycle();

      // Illegal store funct3
      drive(1'b0, 1'b1, 3'b011, 32'h1C, 32'hFFFF_FFFF);
      sample();
      check("st_illegal_we",    {31'b0, bus.DM_WE},  32'h0);
      check("st_illegal_stall", {31'b0, bus.StallM}, 32'h0);
      cycle();
      drive(1'b0, 1'b0, F3_W, 32'h0, 32'h0);
      check("st_illegal_mem", mem[7], 32'h0102_0304);

      // Reset during MERGE
      store_word(32'h18, 32'h5566_7788);
      drive(1'b0, 1'b1, F3_B, 32'h19, 32'h0000_0099);
      sample();
      check("rstm_stall_idle", {31'b0, bus.StallM}, 32'h1);
      cycle();
      rst = 1'b1;
      sample();
      check("rstm_we",    {31'b0, bus.DM_WE},  32'h0);
      check("rstm_stall", {31'b0, bus.StallM}, 32'h0);
      cycle();
      rst = 1'b0;
      drive(1'b1, 1'b0, F3_W, 32'h18, 32'h0);
      sample();
      check("rstm_idle_load", bus.ReadDataM, 32'h5566_7788);
      check("rstm_mem",       mem[6],        32'h5566_7788);
      cycle();

      // Misaligned word store and halfword load
      drive(1'b0, 1'b1, F3_W, 32'h11, 32'hCAFE_F00D);
      sample();
`ifdef MEM_MISALIGN_TRAP_EN
      check("mis_sw_flag", {31'b0, bus.MisalignedM}, 32'h1);
      check("mis_sw_we",   {31'b0, bus.DM_WE},       32'h0);
`else
      check("mis_sw_flag", {31'b0, bus.MisalignedM}, 32'h0);
      check("mis_sw_we",   {31'b0, bus.DM_WE},       32'h1);
      check("mis_sw_addr", {24'b0, bus.DM_Addr},     32'h4);
`endif
      cycle();
      drive(1'b1, 1'b0, F3_W, 32'h10, 32'h0);
      sample();
`ifdef MEM_MISALIGN_TRAP_EN
      check("mis_sw_mem", bus.ReadDataM, 32'hDEAD_BEEF);
`else
      check("mis_sw_mem", bus.ReadDataM, 32'hCAFE_F00D);
`endif
      cycle();
      drive(1'b1, 1'b0, F3_H, 32'h0D, 32'h0);
      sample();
`ifdef MEM_MISALIGN_TRAP_EN
      check("mis_lh_flag", {31'b0, bus.MisalignedM}, 32'h1);
      check("mis_lh_rd",   bus.ReadDataM,            32'h0);
`else
      check("mis_lh_flag", {31'b0, bus.MisalignedM}, 32'h0);
      check("mis_lh_rd",   bus.ReadDataM,            32'h0000_22F1);
`endif
      cycle();
      drive(1'b0, 1'b0, F3_W, 32'h0, 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
